// File: rtl/bomb_game_if.sv
// Signal bundle between the bomb game controller and its surroundings.
// The controller sits on the slave side; the stimulus/board side is the master.
interface bomb_game_if #(
  parameter int unsigned NWIRES = 4
);
  logic              tick_1hz;
  logic              arm_btn;
  logic [NWIRES-1:0] wire_cut;
  logic              start;
  logic              success;
  logic              boom;
  logic [3:0]        time_tens;
  logic [3:0]        time_ones;
  logic [1:0]        strikes;
  logic              strike_pulse;
  logic [1:0]        state;

  modport master (
    output tick_1hz, arm_btn, wire_cut,
    input  start, success, boom, time_tens, time_ones, strikes, strike_pulse, state
  );

  modport slave (
    input  tick_1hz, arm_btn, wire_cut,
    output start, success, boom, time_tens, time_ones, strikes, strike_pulse, state
  );
endinterface

// File: rtl/bomb_game_ctrl.sv
// Round sequencer for the bomb game: arm, BCD countdown, wire-cut judging
// with strikes and time penalties, defuse/explode decision. All outputs registered.
module bomb_game_ctrl #(
  parameter int unsigned       INIT_SEC    = 20,
  parameter int unsigned       NWIRES      = 4,
  parameter logic [NWIRES-1:0] SAFE_MASK   = 4'b0101,
  parameter logic [NWIRES-1:0] TRAP_MASK   = 4'b1010,
  parameter int unsigned       MAX_STRIKES = 3,
  parameter int unsigned       PENALTY_SEC = 5
) (
  input logic        clk,
  input logic        rst,
  bomb_game_if.slave bus_io
);

  if ((SAFE_MASK & TRAP_MASK) != '0) begin : g_mask_overlap
    $error("bomb_game_ctrl: SAFE_MASK and TRAP_MASK overlap");
  end
  if (INIT_SEC < 1 || INIT_SEC > 99) begin : g_init_range
    $error("bomb_game_ctrl: INIT_SEC must be 1..99");
  end
  if (MAX_STRIKES < 1 || MAX_STRIKES > 3) begin : g_strike_range
    $error("bomb_game_ctrl: MAX_STRIKES must be 1..3");
  end
  if (PENALTY_SEC > 99) begin : g_pen_range
    $error("bomb_game_ctrl: PENALTY_SEC must be 0..99");
  end

  localparam logic [3:0] InitTens   = 4'(INIT_SEC / 10);
  localparam logic [3:0] InitOnes   = 4'(INIT_SEC % 10);
  localparam logic [7:0] Penalty    = 8'(PENALTY_SEC);
  localparam logic [1:0] MaxStrikes = 2'(MAX_STRIKES);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArmed    = 2'd1,
    StDefused  = 2'd2,
    StExploded = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        tens_q, tens_d, ones_q, ones_d;
  logic [1:0]        strikes_q, strikes_d;
  logic              pulse_q, pulse_d;
  logic [NWIRES-1:0] wire_prev_q;
  logic              start_q, success_q, boom_q;

  logic [NWIRES-1:0] new_cut;
  logic              trap_hit;
  logic [7:0]        dec, total, total_nxt;
  logic [1:0]        strikes_inc;

  always_comb begin
    new_cut     = bus_io.wire_cut & ~wire_prev_q;
    trap_hit    = |(new_cut & TRAP_MASK);
    dec         = 8'(bus_io.tick_1hz) + (trap_hit ? Penalty : 8'd0);
    total       = 8'(tens_q) * 8'd10 + 8'(ones_q);
    // Saturate at zero rather than wrapping below 00.
    total_nxt   = (dec >= total) ? 8'd0 : total - dec;
    strikes_inc = strikes_q + 2'(trap_hit);

    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    strikes_d = strikes_q;
    pulse_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.arm_btn && bus_io.wire_cut == '0) begin
          state_d   = StArmed;
          tens_d    = InitTens;
          ones_d    = InitOnes;
          strikes_d = 2'd0;
        end
      end
      StArmed: begin
        tens_d    = 4'(total_nxt / 8'd10);
        ones_d    = 4'(total_nxt % 8'd10);
        strikes_d = strikes_inc;
        pulse_d   = trap_hit;
        // Explosion is checked first so it wins over a simultaneous defuse.
        if (strikes_inc == MaxStrikes || total_nxt == 8'd0) begin
          state_d = StExploded;
        end else if ((bus_io.wire_cut & SAFE_MASK) == SAFE_MASK) begin
          state_d = StDefused;
        end
      end
      StDefused, StExploded: begin
        if (bus_io.arm_btn) begin
          state_d   = StIdle;
          tens_d    = InitTens;
          ones_d    = InitOnes;
          strikes_d = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tens_q      <= InitTens;
      ones_q      <= InitOnes;
      strikes_q   <= 2'd0;
      pulse_q     <= 1'b0;
      wire_prev_q <= '0;
      start_q     <= 1'b0;
      success_q   <= 1'b0;
      boom_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      strikes_q   <= strikes_d;
      pulse_q     <= pulse_d;
      wire_prev_q <= bus_io.wire_cut;
      start_q     <= (state_d == StArmed);
      success_q   <= (state_d == StDefused);
      boom_q      <= (state_d == StExploded);
    end
  end

  assign bus_io.start        = start_q;
  assign bus_io.success      = success_q;
  assign bus_io.boom         = boom_q;
  assign bus_io.time_tens    = tens_q;
  assign bus_io.time_ones    = ones_q;
  assign bus_io.strikes      = strikes_q;
  assign bus_io.strike_pulse = pulse_q;
  assign bus_io.state        = state_q;

endmodule
